// File: rtl/moore_seq_detector.sv
// Parametrised Moore serial pattern detector with loadable pattern,
// overlap select, input qualifier and saturating match counter.
// Ports: clk_i, rst_i (async, active-low), valid_i, x_i, ovl_i,
//   pat_load_i, pat_i[PAT_W], cnt_clr_i -> y_o, cnt_o[CNT_W], cnt_sat_o.
module moore_seq_detector #(
  parameter int unsigned      PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = 3'b101,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             x_i,
  input  logic             ovl_i,
  input  logic             pat_load_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic             cnt_clr_i,
  output logic             y_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             cnt_sat_o
);

  localparam int unsigned FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  typedef enum logic [1:0] {
    S_FILL,
    S_HUNT,
    S_DETECT
  } state_t;

  state_t state_q, state_d;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;

  logic             beat;
  logic [PAT_W-1:0] shift;
  logic [FW-1:0]    fill_inc;
  logic             match;

  // Window datapath; load takes priority and drops the beat.
  always_comb begin
    beat     = valid_i & ~pat_load_i;
    shift    = {hist_q[PAT_W-2:0], x_i};
    fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    match    = beat && (shift == pat_q) && (fill_inc == FULL);
    pat_d    = pat_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    if (pat_load_i) begin
      pat_d  = pat_i;
      hist_d = '0;
      fill_d = '0;
    end else if (match && !ovl_i) begin
      // Non-overlap: consumed bits cannot seed the next match.
      hist_d = '0;
      fill_d = '0;
    end else if (beat) begin
      hist_d = shift;
      fill_d = fill_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pat_q  <= PAT_RST;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (pat_load_i) begin
      state_d = S_FILL;
    end else if (match) begin
      state_d = S_DETECT;
    end else begin
      unique case (state_q)
        S_FILL:   state_d = (fill_d == FULL) ? S_HUNT : S_FILL;
        S_HUNT:   state_d = S_HUNT;
        // Window is full only if the match was overlapping.
        S_DETECT: state_d = (fill_d == FULL) ? S_HUNT : S_FILL;
        default:  state_d = S_FILL;
      endcase
    end
  end

  always_comb begin
    y_o = (state_q == S_DETECT);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (match) begin
      if (&cnt_q) begin
        sat_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_sat_o = sat_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Bench for moore_seq_detector: directed scenarios plus random
// traffic checked against a bit-queue reference model.
module tb_moore_seq_detector;

  localparam int unsigned PAT_W = 3;
  localparam int unsigned CNT_W = 2;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             valid_i = 1'b0;
  logic             x_i = 1'b0;
  logic             ovl_i = 1'b0;
  logic             pat_load_i = 1'b0;
  logic [PAT_W-1:0] pat_i = '0;
  logic             cnt_clr_i = 1'b0;
  logic             y_o;
  logic [CNT_W-1:0] cnt_o;
  logic             cnt_sat_o;

  moore_seq_detector #(
    .PAT_W  (PAT_W),
    .PAT_RST(3'b101),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .x_i       (x_i),
    .ovl_i     (ovl_i),
    .pat_load_i(pat_load_i),
    .pat_i     (pat_i),
    .cnt_clr_i (cnt_clr_i),
    .y_o       (y_o),
    .cnt_o     (cnt_o),
    .cnt_sat_o (cnt_sat_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int npulse = 0;
  bit g_ovl = 1'b1;

  // Reference: accepted bits since the last clearing event.
  int         q[$];
  logic [2:0] m_pat = 3'b101;
  int         m_cnt = 0;
  bit         m_sat = 1'b0;
  bit         m_y = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qval();
    int v;
    v = 0;
    foreach (q[i]) v = (v << 1) | q[i];
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pat = 3'b101;
    m_cnt = 0;
    m_sat = 1'b0;
    m_y   = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit x, input bit o,
                            input bit ld, input logic [2:0] p,
                            input bit cl);
    bit m;
    m = 1'b0;
    if (ld) begin
      m_pat = p;
      q.delete();
    end else if (v) begin
      q.push_back(int'(x));
      if (q.size() > PAT_W) void'(q.pop_front());
      if (q.size() == PAT_W && qval() == int'(m_pat)) begin
        m = 1'b1;
        if (!o) q.delete();
      end
    end
    m_y = m;
    if (cl) begin
      m_cnt = 0;
      m_sat = 1'b0;
    end else if (m) begin
      if (m_cnt == CMAX) m_sat = 1'b1;
      else m_cnt++;
    end
  endtask

  // Check state from the previous edge, then drive the next beat.
  task automatic cycle(input bit v, input bit x, input bit o,
                       input bit ld, input logic [2:0] p,
                       input bit cl);
    @(negedge clk);
    chk("y", int'(y_o), int'(m_y));
    chk("cnt", int'(cnt_o), m_cnt);
    chk("sat", int'(cnt_sat_o), int'(m_sat));
    if (y_o) npulse++;
    valid_i    = v;
    x_i        = x;
    ovl_i      = o;
    pat_load_i = ld;
    pat_i      = p;
    cnt_clr_i  = cl;
    model_step(v, x, o, ld, p, cl);
  endtask

  task automatic bt(input bit x);
    cycle(1'b1, x, g_ovl, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic idle(input bit x);
    cycle(1'b0, x, g_ovl, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid_i    = 1'b0;
    pat_load_i = 1'b0;
    cnt_clr_i  = 1'b0;
    #1 rst_i = 1'b0;
    #1;
    chk("rst_y", int'(y_o), 0);
    chk("rst_cnt", int'(cnt_o), 0);
    chk("rst_sat", int'(cnt_sat_o), 0);
    model_reset();
    @(posedge clk);
    #2 rst_i = 1'b1;
    npulse = 0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // 1: overlap
    g_ovl = 1'b1;
    bt(1); bt(0); bt(1); bt(0); bt(1); idle(0);
    chk("t1_pulses", npulse, 2);
    chk("t1_cnt", int'(cnt_o), 2);

    // 2: non-overlap
    do_reset();
    g_ovl = 1'b0;
    bt(1); bt(0); bt(1); bt(0); bt(1); idle(0);
    chk("t2_pulses_a", npulse, 1);
    bt(1); bt(0); bt(1); idle(0);
    chk("t2_pulses_b", npulse, 2);
    chk("t2_cnt", int'(cnt_o), 2);

    // 3: valid gaps
    do_reset();
    g_ovl = 1'b1;
    bt(1); idle(1); idle(0); idle(1); bt(0); bt(1);
    idle(1); idle(0); idle(1);
    chk("t3_pulses", npulse, 1);

    // 4: reload mid-stream, beat in load cycle dropped
    do_reset();
    bt(1); bt(0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 3'b110, 1'b0);
    idle(0);
    chk("t4_pulses_a", npulse, 0);
    bt(1); bt(1); idle(0);
    chk("t4_pulses_b", npulse, 0);
    bt(0); idle(0);
    chk("t4_pulses_c", npulse, 1);

    // 5: saturation, then clear racing a match
    do_reset();
    bt(1);
    for (int i = 0; i < 5; i++) begin
      bt(0); bt(1);
    end
    idle(0);
    chk("t5_pulses", npulse, 5);
    chk("t5_cnt", int'(cnt_o), 3);
    chk("t5_sat", int'(cnt_sat_o), 1);
    bt(0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    idle(0);
    chk("t5_clr_cnt", int'(cnt_o), 0);
    chk("t5_clr_sat", int'(cnt_sat_o), 0);
    chk("t5_clr_y", int'(y_o), 1);

    // 6: reset mid-operation
    do_reset();
    bt(1); bt(0); bt(1); bt(1); bt(0);
    do_reset();
    bt(1); idle(0); idle(0);
    chk("t6_pulses_a", npulse, 0);
    bt(1); bt(0); bt(1); idle(0);
    chk("t6_pulses_b", npulse, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)),
              $urandom_range(0, 2) != 0,
              $urandom_range(0, 39) == 0,
              3'($urandom_range(0, 7)),
              $urandom_range(0, 59) == 0);
      end
    end
    idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
